bit_stream_deserializer: RTL and testbench

BIT_STREAM_DESERIALIZER -- requirements
Module: bit_stream_deserializer

---
 rtl/bit_stream_pkg.sv | 17 +
 rtl/bit_stream_deserializer.sv | 89 ++++++++
 tb/tb_bit_stream_deserializer.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/bit_stream_pkg.sv
//----------------------------------------------------------------------------
// Module : bit_stream_pkg
// Brief  : Shared types for the serial bit-stream stages.
// Rev    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

package bit_stream_pkg;

   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      COLLECT = 1'b1
   } bs_state_t;

endpackage : bit_stream_pkg

`default_nettype wire

// File: rtl/bit_stream_deserializer.sv
//----------------------------------------------------------------------------
// Module : bit_stream_deserializer
// Brief  : Packs a valid-qualified serial bit stream into WIDTH-bit words,
//          with early word termination on data_last_i.
// Rev    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module bit_stream_deserializer
   import bit_stream_pkg::*;
#(
   parameter int WIDTH     = 20,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic                     clk_i,
   input  logic                     srst_i,
   input  logic                     data_i,
   input  logic                     data_val_i,
   input  logic                     data_last_i,
   output logic [WIDTH-1:0]         data_o,
   output logic [$clog2(WIDTH):0]   data_mod_o,
   output logic                     data_val_o
);

   localparam int C_CW = $clog2(WIDTH);
   localparam int C_MW = C_CW + 1;

   bs_state_t        r_state;
   bs_state_t        w_state_next;
   logic [C_CW-1:0]  r_cnt;
   logic [WIDTH-1:0] r_asm;
   logic [WIDTH-1:0] r_data;
   logic [C_MW-1:0]  r_mod;
   logic             r_val;

   logic [C_CW-1:0]  w_pos;
   logic [WIDTH-1:0] w_asm_bit;
   logic             w_done;

   assign w_pos     = MSB_FIRST ? (C_CW'(WIDTH - 1) - r_cnt) : r_cnt;
   // The assembly register is cleared after every word, so OR-ing in the new
   // bit leaves every unfilled position at zero.
   assign w_asm_bit = r_asm | (WIDTH'(data_i) << w_pos);
   assign w_done    = data_val_i & (data_last_i | (r_cnt == C_CW'(WIDTH - 1)));

   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      if (data_val_i) begin
         w_state_next = w_done ? IDLE : COLLECT;
      end
   end

   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         r_cnt  <= '0;
         r_asm  <= '0;
         r_data <= '0;
         r_mod  <= '0;
         r_val  <= 1'b0;
      end else begin
         r_val <= 1'b0;
         if (w_done) begin
            r_data <= w_asm_bit;
            r_mod  <= C_MW'(r_cnt) + C_MW'(1);
            r_val  <= 1'b1;
            r_cnt  <= '0;
            r_asm  <= '0;
         end else if (data_val_i) begin
            r_asm <= w_asm_bit;
            r_cnt <= r_cnt + C_CW'(1);
         end
      end
   end

   assign data_o     = r_data;
   assign data_mod_o = r_mod;
   assign data_val_o = r_val;

endmodule : bit_stream_deserializer

`default_nettype wire

// File: tb/tb_bit_stream_deserializer.sv
//----------------------------------------------------------------------------
// Module : tb_bit_stream_deserializer
// Brief  : Directed bench driving an MSB-first and an LSB-first instance.
// Rev    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module tb_bit_stream_deserializer;

   localparam int W  = 20;
   localparam int MW = $clog2(W) + 1;

   logic          clk_i = 1'b0;
   logic          srst_i, data_i, data_val_i, data_last_i;
   logic [W-1:0]  dm, dl;
   logic [MW-1:0] mm, ml;
   logic          vm, vl;

   always #5 clk_i = ~clk_i;

   bit_stream_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
      .clk_i(clk_i), .srst_i(srst_i), .data_i(data_i), .data_val_i(data_val_i),
      .data_last_i(data_last_i), .data_o(dm), .data_mod_o(mm), .data_val_o(vm)
   );

   bit_stream_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
      .clk_i(clk_i), .srst_i(srst_i), .data_i(data_i), .data_val_i(data_val_i),
      .data_last_i(data_last_i), .data_o(dl), .data_mod_o(ml), .data_val_o(vl)
   );

   typedef struct {
      int           n;
      logic [W-1:0] pat;     // bit k is the k-th accepted bit
      logic         last;
      logic [W-1:0] exp_m;
      logic [W-1:0] exp_l;
      int           mod;
   } vec_t;

   vec_t vecs [7];
   int   checks  = 0;
   int   errors  = 0;
   int   strobes = 0;
   int   cyc     = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic step(input logic v, input logic d, input logic l, input logic r);
      srst_i      = r;
      data_val_i  = v;
      data_i      = d;
      data_last_i = l;
      @(posedge clk_i);
      #1;
      cyc++;
      if (vm) strobes++;
   endtask

   initial begin
      logic [W-1:0] hold_m, hold_l;
      int           s0, n_str;
      int           str_cyc [2];

      vecs[0] = '{20, 20'h55555, 1'b0, 20'hAAAAA, 20'h55555, 20};
      vecs[1] = '{ 5, 20'h0001B, 1'b1, 20'hD8000, 20'h0001B,  5};
      vecs[2] = '{ 1, 20'h00001, 1'b1, 20'h80000, 20'h00001,  1};
      vecs[3] = '{ 1, 20'h00000, 1'b1, 20'h00000, 20'h00000,  1};
      vecs[4] = '{20, 20'h00001, 1'b1, 20'h80000, 20'h00001, 20};
      vecs[5] = '{19, 20'h7FFFF, 1'b1, 20'hFFFFE, 20'h7FFFF, 19};
      vecs[6] = '{ 8, 20'h00081, 1'b1, 20'h81000, 20'h00081,  8};

      // Reset held two cycles with a valid bit present
      for (int i = 0; i < 2; i++) begin
         step(1'b1, 1'b1, 1'b0, 1'b1);
         chk("rst_val", 32'(vm), 32'(0));
         chk("rst_data", 32'(dm), 32'(0));
         chk("rst_mod", 32'(mm), 32'(0));
      end
      step(1'b0, 1'b0, 1'b0, 1'b0);
      chk("post_rst_val", 32'(vm), 32'(0));
      chk("post_rst_data", 32'(dm), 32'(0));

      hold_m = '0;
      hold_l = '0;
      for (int i = 0; i < 7; i++) begin
         s0 = strobes;
         for (int k = 0; k < vecs[i].n; k++) begin
            logic [W-1:0] p;
            logic         fin;
            p   = vecs[i].pat;
            fin = (k == vecs[i].n - 1);
            step(1'b1, p[k], fin & vecs[i].last, 1'b0);
            if (!fin) begin
               chk($sformatf("v%0d_busy_val", i), 32'(vm), 32'(0));
               chk($sformatf("v%0d_hold_m", i), 32'(dm), 32'(hold_m));
               chk($sformatf("v%0d_hold_l", i), 32'(dl), 32'(hold_l));
            end else begin
               chk($sformatf("v%0d_val_m", i), 32'(vm), 32'(1));
               chk($sformatf("v%0d_val_l", i), 32'(vl), 32'(1));
               chk($sformatf("v%0d_data_m", i), 32'(dm), 32'(vecs[i].exp_m));
               chk($sformatf("v%0d_data_l", i), 32'(dl), 32'(vecs[i].exp_l));
               chk($sformatf("v%0d_mod_m", i), 32'(mm), 32'(vecs[i].mod));
               chk($sformatf("v%0d_mod_l", i), 32'(ml), 32'(vecs[i].mod));
            end
         end
         hold_m = vecs[i].exp_m;
         hold_l = vecs[i].exp_l;
         step(1'b0, 1'b1, 1'b1, 1'b0);
         chk($sformatf("v%0d_strobe_drop", i), 32'(vm), 32'(0));
         chk($sformatf("v%0d_after_m", i), 32'(dm), 32'(hold_m));
         chk($sformatf("v%0d_strobes", i), 32'(strobes - s0), 32'(1));
      end

      // Twenty ones with random idle gaps
      s0 = strobes;
      for (int k = 0; k < 20; k++) begin
         if ($urandom_range(0, 1) == 1) begin
            step(1'b0, 1'b0, 1'b1, 1'b0);
            chk("gap_idle_val", 32'(vm), 32'(0));
         end
         step(1'b1, 1'b1, 1'b0, 1'b0);
      end
      chk("gap_val", 32'(vm), 32'(1));
      chk("gap_data", 32'(dm), 32'(20'hFFFFF));
      chk("gap_mod", 32'(mm), 32'(20));
      step(1'b0, 1'b0, 1'b0, 1'b0);
      chk("gap_strobes", 32'(strobes - s0), 32'(1));

      // Partial word discarded by reset; the bit in the reset cycle is dropped
      s0 = strobes;
      for (int k = 0; k < 7; k++) step(1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b1);
      chk("mid_rst_data", 32'(dm), 32'(0));
      chk("mid_rst_mod", 32'(mm), 32'(0));
      step(1'b0, 1'b0, 1'b0, 1'b0);
      chk("mid_rst_val", 32'(vm), 32'(0));
      for (int k = 0; k < 20; k++) step(1'b1, 1'b0, 1'b0, 1'b0);
      chk("mid_val", 32'(vm), 32'(1));
      chk("mid_data", 32'(dm), 32'(0));
      chk("mid_mod", 32'(mm), 32'(20));
      chk("mid_strobes", 32'(strobes - s0), 32'(1));

      // Back-to-back words, then one-bit words on consecutive cycles
      n_str = 0;
      str_cyc[0] = 0;
      str_cyc[1] = 0;
      for (int k = 0; k < 40; k++) begin
         step(1'b1, (k % 3) == 0, 1'b0, 1'b0);
         if (vm) begin
            if (n_str < 2) str_cyc[n_str] = cyc;
            n_str++;
         end
      end
      chk("b2b_count", 32'(n_str), 32'(2));
      chk("b2b_spacing", 32'(str_cyc[1] - str_cyc[0]), 32'(20));
      for (int k = 0; k < 3; k++) begin
         step(1'b1, 1'b1, 1'b1, 1'b0);
         chk($sformatf("last%0d_val", k), 32'(vm), 32'(1));
         chk($sformatf("last%0d_mod", k), 32'(mm), 32'(1));
         chk($sformatf("last%0d_data", k), 32'(dm), 32'(20'h80000));
      end
      step(1'b0, 1'b0, 1'b0, 1'b0);
      chk("last_end_val", 32'(vm), 32'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_bit_stream_deserializer

`default_nettype wire
